// File: rtl/hdng_pid_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : hdng_pid_gen                                               |
// | Description : Heading PID controller; turns heading error into          |
// |               saturated left/right wheel speeds through a 3-stage pipe.  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module hdng_pid_gen #(
   parameter int         HDNG_W     = 12,
   parameter int         SPD_W      = 11,
   parameter int         AT_THRESH  = 30,
   parameter int         SETTLE_CNT = 4,
   parameter int         P_DFLT     = 3,
   parameter int         D_DFLT     = 14,
   parameter logic [1:0] MODE_DFLT  = 2'b11
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     moving,
   input  logic                     hdng_vld,
   input  logic signed [HDNG_W-1:0] dsrd_hdng,
   input  logic signed [HDNG_W-1:0] actl_hdng,
   input  logic        [SPD_W-1:0]  frwrd_spd,
   input  logic                     gain_wr,
   input  logic        [1:0]        gain_sel,
   input  logic        [7:0]        gain_data,
   output logic signed [SPD_W:0]    lft_spd,
   output logic signed [SPD_W:0]    rght_spd,
   output logic                     spd_vld,
   output logic                     at_hdng
);

   localparam int c_ERR_W  = 10;
   localparam int c_P_W    = 14;
   localparam int c_I_W    = 12;
   localparam int c_DD_W   = 8;
   localparam int c_D_W    = 13;
   localparam int c_SUM_W  = 15;
   localparam int c_CORR_W = c_SUM_W - 3;
   localparam int c_OUT_W  = SPD_W + 1;
   localparam int c_LR_W   = ((SPD_W > c_CORR_W) ? SPD_W : c_CORR_W) + 2;
   localparam int c_CNT_W  = $clog2(SETTLE_CNT + 2);

   localparam logic signed [HDNG_W-1:0]  c_ERR_HI  = HDNG_W'(511);
   localparam logic signed [HDNG_W-1:0]  c_ERR_LO  = HDNG_W'(-512);
   localparam logic signed [c_ERR_W-1:0] c_ESAT_HI = 10'sh1FF;
   localparam logic signed [c_ERR_W-1:0] c_ESAT_LO = 10'sh200;
   localparam logic signed [c_ERR_W:0]   c_DD_HI   = 11'sh07F;
   localparam logic signed [c_ERR_W:0]   c_DD_LO   = 11'sh780;
   localparam logic signed [c_DD_W-1:0]  c_DSAT_HI = 8'sh7F;
   localparam logic signed [c_DD_W-1:0]  c_DSAT_LO = 8'sh80;
   localparam logic        [c_ERR_W:0]   c_AT_THR  = 11'(AT_THRESH);
   localparam logic        [c_CNT_W-1:0] c_SETTLE  = c_CNT_W'(SETTLE_CNT);
   localparam logic        [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);
   localparam logic signed [c_LR_W-1:0]  c_OUT_HI  = c_LR_W'((2**SPD_W) - 1);
   localparam logic signed [c_LR_W-1:0]  c_OUT_LO  = c_LR_W'(-(2**SPD_W));
   localparam logic        [3:0]         c_P_DFLT  = 4'(P_DFLT);
   localparam logic        [4:0]         c_D_DFLT  = 5'(D_DFLT);

   function automatic logic signed [c_OUT_W-1:0] sat_out(input logic signed [c_LR_W-1:0] v);
      logic signed [c_OUT_W-1:0] res;
      if (v > c_OUT_HI)      res = c_OUT_HI[c_OUT_W-1:0];
      else if (v < c_OUT_LO) res = c_OUT_LO[c_OUT_W-1:0];
      else                   res = v[c_OUT_W-1:0];
      return res;
   endfunction

   logic        [3:0]          r_p_gain;
   logic        [4:0]          r_d_gain;
   logic        [1:0]          r_mode;
   logic                       r_v1, r_v2, r_v3;
   logic signed [c_ERR_W-1:0]  r_err_s1, r_hist1, r_hist2;
   logic signed [15:0]         r_integ;
   logic        [c_CNT_W-1:0]  r_cnt;
   logic                       r_at;
   logic signed [c_P_W-1:0]    r_p;
   logic signed [c_I_W-1:0]    r_i;
   logic signed [c_D_W-1:0]    r_d;
   logic signed [c_OUT_W-1:0]  r_lft, r_rght;

   logic signed [HDNG_W-1:0]   w_err_raw;
   logic signed [c_ERR_W-1:0]  w_err_sat;
   logic signed [c_P_W-1:0]    w_p;
   logic signed [16:0]         w_integ_sum;
   logic signed [15:0]         w_integ_nxt;
   logic signed [c_I_W-1:0]    w_i;
   logic signed [c_ERR_W:0]    w_dd_raw;
   logic signed [c_DD_W-1:0]   w_dd;
   logic signed [c_D_W-1:0]    w_d;
   logic        [c_ERR_W:0]    w_err_abs;
   logic        [c_CNT_W-1:0]  w_cnt_nxt;
   logic signed [c_SUM_W-1:0]  w_sum;
   logic signed [c_CORR_W-1:0] w_corr;
   logic signed [c_LR_W-1:0]   w_frwrd_x, w_corr_x, w_lft_raw, w_rght_raw;
   logic                       w_unused_gain;

   assign w_unused_gain = ^gain_data[7:5];

   // Heading error wraps modulo 2^HDNG_W before being clamped to 10 bits
   always_comb begin
      w_err_raw = actl_hdng - dsrd_hdng;
      if (w_err_raw > c_ERR_HI)      w_err_sat = c_ESAT_HI;
      else if (w_err_raw < c_ERR_LO) w_err_sat = c_ESAT_LO;
      else                           w_err_sat = w_err_raw[c_ERR_W-1:0];
   end

   always_comb begin
      w_p = $signed({{(c_P_W-c_ERR_W){r_err_s1[c_ERR_W-1]}}, r_err_s1})
          * $signed({{(c_P_W-4){1'b0}}, r_p_gain});

      w_integ_sum = $signed({r_integ[15], r_integ})
                  + $signed({{7{r_err_s1[c_ERR_W-1]}}, r_err_s1});
      if (w_integ_sum[16] != w_integ_sum[15])
         w_integ_nxt = w_integ_sum[16] ? 16'sh8000 : 16'sh7FFF;
      else
         w_integ_nxt = w_integ_sum[15:0];
      w_i = c_I_W'(w_integ_nxt >>> 4);

      w_dd_raw = $signed({r_err_s1[c_ERR_W-1], r_err_s1}) - $signed({r_hist2[c_ERR_W-1], r_hist2});
      if (w_dd_raw > c_DD_HI)      w_dd = c_DSAT_HI;
      else if (w_dd_raw < c_DD_LO) w_dd = c_DSAT_LO;
      else                         w_dd = w_dd_raw[c_DD_W-1:0];
      w_d = $signed({{(c_D_W-c_DD_W){w_dd[c_DD_W-1]}}, w_dd})
          * $signed({{(c_D_W-5){1'b0}}, r_d_gain});

      w_err_abs = r_err_s1[c_ERR_W-1] ? -$signed({r_err_s1[c_ERR_W-1], r_err_s1})
                                      :  $signed({r_err_s1[c_ERR_W-1], r_err_s1});
      if (w_err_abs >= c_AT_THR)  w_cnt_nxt = '0;
      else if (r_cnt >= c_SETTLE) w_cnt_nxt = r_cnt;
      else                        w_cnt_nxt = r_cnt + c_CNT_ONE;
   end

   always_comb begin
      w_sum = $signed({{(c_SUM_W-c_P_W){r_p[c_P_W-1]}}, r_p})
            + $signed({{(c_SUM_W-c_I_W){r_i[c_I_W-1]}}, r_i})
            + $signed({{(c_SUM_W-c_D_W){r_d[c_D_W-1]}}, r_d});
      w_corr     = c_CORR_W'(w_sum >>> 3);
      w_corr_x   = $signed({{(c_LR_W-c_CORR_W){w_corr[c_CORR_W-1]}}, w_corr});
      w_frwrd_x  = $signed({{(c_LR_W-SPD_W){1'b0}}, frwrd_spd});
      w_lft_raw  = w_frwrd_x + w_corr_x;
      w_rght_raw = w_frwrd_x - w_corr_x;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_p_gain <= c_P_DFLT;
         r_d_gain <= c_D_DFLT;
         r_mode   <= MODE_DFLT;
      end else if (gain_wr) begin
         case (gain_sel)
            2'd0:    r_p_gain <= gain_data[3:0];
            2'd1:    r_d_gain <= gain_data[4:0];
            2'd2:    r_mode   <= gain_data[1:0];
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_v1 <= 1'b0;  r_err_s1 <= '0;
         r_v2 <= 1'b0;  r_p <= '0;  r_i <= '0;  r_d <= '0;
         r_hist1 <= '0; r_hist2 <= '0;
         r_integ <= '0; r_cnt <= '0; r_at <= 1'b0;
         r_v3 <= 1'b0;  r_lft <= '0; r_rght <= '0;
      end else begin
         r_v1 <= hdng_vld;
         if (hdng_vld) r_err_s1 <= w_err_sat;

         r_v2 <= r_v1;
         if (r_v1) begin
            r_p     <= w_p;
            r_i     <= r_mode[0] ? w_i : '0;
            r_d     <= r_mode[1] ? w_d : '0;
            r_hist1 <= r_err_s1;
            r_hist2 <= r_hist1;
         end
         // Integrator and settle state restart whenever the robot stops
         if (!moving) begin
            r_integ <= '0;
            r_cnt   <= '0;
            r_at    <= 1'b0;
         end else if (r_v1) begin
            r_integ <= w_integ_nxt;
            r_cnt   <= w_cnt_nxt;
            r_at    <= (w_cnt_nxt >= c_SETTLE);
         end

         r_v3 <= r_v2;
         if (!moving) begin
            r_lft  <= '0;
            r_rght <= '0;
         end else if (r_v2) begin
            r_lft  <= sat_out(w_lft_raw);
            r_rght <= sat_out(w_rght_raw);
         end
      end
   end

   assign lft_spd  = r_lft;
   assign rght_spd = r_rght;
   assign spd_vld  = r_v3;
   assign at_hdng  = r_at;

endmodule
`default_nettype wire

// File: doc/hdng_pid_gen.md
HDNG_PID_GEN -- requirements
Module: hdng_pid_gen

Interface
REQ-001 SHALL have parameter HDNG_W, default 12, heading/error width.
REQ-002 SHALL have parameter SPD_W, default 11, forward-speed width; speed outputs are SPD_W+1 signed.
REQ-003 SHALL have parameter AT_THRESH, default 30, at-heading magnitude threshold.
REQ-004 SHALL have parameter SETTLE_CNT, default 4, consecutive in-threshold samples required for at_hdng.
REQ-005 SHALL have parameters P_DFLT=3, D_DFLT=14, MODE_DFLT=2'b11: gain and mode reset values.
REQ-006 SHALL have port clk, input, 1, clock; all state updates on rising edge.
REQ-007 SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-008 SHALL have ports moving (input, 1, enable) and hdng_vld (input, 1, new heading sample).
REQ-009 SHALL have ports dsrd_hdng and actl_hdng, input, HDNG_W signed each.
REQ-010 SHALL have port frwrd_spd, input, SPD_W unsigned.
REQ-011 SHALL have ports gain_wr (input, 1), gain_sel (input, 2) and gain_data (input, 8), the gain write port.
REQ-012 SHALL have ports lft_spd and rght_spd, output, SPD_W+1 signed, registered.
REQ-013 SHALL have ports spd_vld (output, 1, one-cycle pulse) and at_hdng (output, 1, registered).

Function
REQ-014 SHALL compute error = actl_hdng - dsrd_hdng modulo 2^HDNG_W, then saturate it to 10-bit signed err_sat (+511/-512).
REQ-015 SHALL run a 3-stage pipeline: S1 registers err_sat on hdng_vld; S2 registers P, I and D terms; S3 registers the speeds; spd_vld pulses 3 cycles after the sampled hdng_vld.
REQ-016 SHALL accept hdng_vld back-to-back, with each sample producing exactly one spd_vld; outputs hold between pulses.
REQ-017 SHALL compute P = err_sat × p_gain, where p_gain is 4-bit unsigned and the result is 14-bit signed.
REQ-018 SHALL implement the integrator as follows.
- 16-bit signed; on each S1 valid with moving=1, integ <= integ + sext(err_sat).
- Saturates at 0x7FFF/0x8000 and never wraps.
- I term = updated integ >>> 4, 12-bit.
- Forced to 0 when mode[0]=0.
REQ-019 SHALL clear the integrator to 0 on any clock where moving=0.
REQ-020 SHALL implement the D term as follows.
- D_diff = err_sat - err_sat from two valid samples earlier; history shifts only on valid samples.
- D_diff saturates to 8-bit signed (+127/-128).
- D = D_diff × d_gain, where d_gain is 5-bit unsigned.
- Forced to 0 when mode[1]=0.
REQ-021 SHALL compute sum = (P + I + D) in 15-bit signed, then corr = sum >>> 3 (arithmetic, floor).
REQ-022 SHALL set lft = frwrd_spd + corr and rght = frwrd_spd - corr, each saturated to SPD_W+1 signed (+2047/-2048 at default).
REQ-023 SHALL register lft_spd and rght_spd as 0 on any clock where moving=0; spd_vld still pulses.
REQ-024 SHALL, on a gain write (gain_wr=1), decode gain_sel as follows.
- 0: p_gain = gain_data[3:0].
- 1: d_gain = gain_data[4:0].
- 2: mode = gain_data[1:0].
- 3: ignored.
REQ-025 SHALL make a gain write at edge k apply to S2 computations registered at edge k+1 onward.
REQ-026 SHALL drive at_hdng as follows.
- Per valid S1 sample, a saturating settle counter increments if |err_sat| < AT_THRESH, else resets to 0 and at_hdng drops the next cycle.
- at_hdng=1 while counter >= SETTLE_CNT.
- moving=0 clears the counter.

Reset
REQ-027 SHALL, on rst_n low, asynchronously clear lft_spd, rght_spd, spd_vld, at_hdng, integrator, D history, settle counter and all pipeline valids, and load gains/mode with P_DFLT/D_DFLT/MODE_DFLT.
REQ-028 SHALL, on reset mid-pipeline, drop in-flight samples: no spd_vld after rst_n release until a new hdng_vld.

Verification
REQ-029 SHALL cover reset: assert rst_n mid-operation -> all outputs 0 immediately; no spd_vld until the next hdng_vld.
REQ-030 SHALL cover zero error: moving=1, frwrd=0x200, actl=dsrd=0, one hdng_vld -> 3 cycles later spd_vld=1, lft=rght=512; at_hdng=1 after the 4th such sample.
REQ-031 SHALL cover saturation: from reset, actl=0x400, dsrd=0, frwrd=0x200 -> err_sat=511, P=1533, I=31, D=1778, lft=929, rght=95, at_hdng=0.
REQ-032 SHALL cover integrator clamp: 70 samples of err_sat=511 -> integrator 32704 after 64 samples, then 32767 and held; no wrap.
REQ-033 SHALL cover gain write: gain_sel=0 data=0 and gain_sel=2 data=0, then the REQ-031 stimulus -> lft=rght=512.
REQ-034 SHALL cover moving drop: with the integrator nonzero, moving=0 -> integrator=0 next clock, lft=rght=0, at_hdng=0.
